// File: rtl/control_unit_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU codes, state encoding and IR field positions.
// The opcode classifier and the top import this package.
package control_unit_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 5;

  // IR field positions
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  // Opcodes
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // ALU_Control codes
  localparam logic [ALUW-1:0] ALU_NONE  = 5'd0;
  localparam logic [ALUW-1:0] ALU_ADD   = 5'd1;
  localparam logic [ALUW-1:0] ALU_SUB   = 5'd2;
  localparam logic [ALUW-1:0] ALU_AND   = 5'd3;
  localparam logic [ALUW-1:0] ALU_OR    = 5'd4;
  localparam logic [ALUW-1:0] ALU_MUL   = 5'd5;
  localparam logic [ALUW-1:0] ALU_DIV   = 5'd6;
  localparam logic [ALUW-1:0] ALU_SHR   = 5'd7;
  localparam logic [ALUW-1:0] ALU_SHL   = 5'd8;
  localparam logic [ALUW-1:0] ALU_SHRA  = 5'd9;
  localparam logic [ALUW-1:0] ALU_ROR   = 5'd10;
  localparam logic [ALUW-1:0] ALU_ROL   = 5'd11;
  localparam logic [ALUW-1:0] ALU_INCPC = 5'd12;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_HALT  = 4'd8
  } state_t;

endpackage

// File: rtl/control_unit_op_classify.sv
// Pure combinational opcode decoder: instruction class flags plus the ALU operation used in T4.
module op_classify
  import control_unit_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_rtype,
  output logic       is_itype,
  output logic       is_muldiv,
  output logic       is_nop,
  output logic       is_halt,
  output logic       is_illegal,
  output logic [4:0] alu_op
);

  always_comb begin
    is_rtype   = 1'b0;
    is_itype   = 1'b0;
    is_muldiv  = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    alu_op     = ALU_NONE;
    case (opcode)
      OP_ADD:  begin is_rtype  = 1'b1; alu_op = ALU_ADD;  end
      OP_SUB:  begin is_rtype  = 1'b1; alu_op = ALU_SUB;  end
      OP_AND:  begin is_rtype  = 1'b1; alu_op = ALU_AND;  end
      OP_OR:   begin is_rtype  = 1'b1; alu_op = ALU_OR;   end
      OP_SHR:  begin is_rtype  = 1'b1; alu_op = ALU_SHR;  end
      OP_SHRA: begin is_rtype  = 1'b1; alu_op = ALU_SHRA; end
      OP_SHL:  begin is_rtype  = 1'b1; alu_op = ALU_SHL;  end
      OP_ROR:  begin is_rtype  = 1'b1; alu_op = ALU_ROR;  end
      OP_ROL:  begin is_rtype  = 1'b1; alu_op = ALU_ROL;  end
      OP_ADDI: begin is_itype  = 1'b1; alu_op = ALU_ADD;  end
      OP_ANDI: begin is_itype  = 1'b1; alu_op = ALU_AND;  end
      OP_ORI:  begin is_itype  = 1'b1; alu_op = ALU_OR;   end
      OP_MUL:  begin is_muldiv = 1'b1; alu_op = ALU_MUL;  end
      OP_DIV:  begin is_muldiv = 1'b1; alu_op = ALU_DIV;  end
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the single-bus datapath: fetch, decode and execute microsteps.
// Outputs depend only on the current state and the opcode field of IR.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        Cout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  ALU_Control,
  output logic        Run,
  output logic        illegal_op
);

  state_t     state_reg, state_next;
  logic       is_rtype, is_itype, is_muldiv, is_nop, is_halt, is_illegal;
  logic [4:0] alu_op;

  // Register fields are consumed by the datapath select logic, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[RA_HI:0];

  op_classify u_op_classify (
    .opcode     (IR[OP_HI:OP_LO]),
    .is_rtype   (is_rtype),
    .is_itype   (is_itype),
    .is_muldiv  (is_muldiv),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_op     (alu_op)
  );

  always_ff @(posedge clk) begin
    if (clr) state_reg <= ST_RESET;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET: state_next = ST_T0;
      ST_T0:    state_next = ST_T1;
      ST_T1:    state_next = mem_ready ? ST_T2 : ST_T1;
      ST_T2:    state_next = ST_T3;
      ST_T3: begin
        if (is_halt)                               state_next = ST_HALT;
        else if (is_rtype || is_itype || is_muldiv) state_next = ST_T4;
        else if (is_nop || is_illegal)             state_next = ST_T0;
        else                                       state_next = ST_T0;
      end
      ST_T4:    state_next = ST_T5;
      ST_T5:    state_next = is_muldiv ? ST_T6 : ST_T0;
      ST_T6:    state_next = ST_T0;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_RESET;
    endcase
    // A stop request is honoured only at an instruction boundary.
    if (stop && state_next == ST_T0) state_next = ST_HALT;
  end

  always_comb begin
    PCout       = 1'b0;
    Zlowout     = 1'b0;
    Zhighout    = 1'b0;
    HIout       = 1'b0;
    LOout       = 1'b0;
    MDRout      = 1'b0;
    Cout        = 1'b0;
    PCin        = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    Read        = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Grc         = 1'b0;
    Rin         = 1'b0;
    Rout        = 1'b0;
    ALU_Control = ALU_NONE;
    Run         = (state_reg != ST_HALT);
    illegal_op  = 1'b0;
    case (state_reg)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1;
        ALU_Control = ALU_INCPC;
      end
      // Holding here re-latches the same Z into PC, so stalls are harmless.
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        if (is_rtype || is_itype) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
        illegal_op = is_illegal;
      end
      ST_T4: begin
        if (is_rtype) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_Control = alu_op;
        end else if (is_itype) begin
          Cout = 1'b1; Zin = 1'b1; ALU_Control = alu_op;
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_Control = alu_op;
        end
      end
      ST_T5: begin
        if (is_rtype || is_itype) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end
      end
      ST_T6: begin
        if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit plus hand sequences for cycle counts, HALT and clr.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, mem_ready, stop;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout, PCin, MARin, MDRin, IRin;
  logic Yin, Zin, HIin, LOin, Read, Gra, Grb, Grc, Rin, Rout, Run, illegal_op;
  logic [4:0] ALU_Control;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .ALU_Control(ALU_Control), .Run(Run), .illegal_op(illegal_op)
  );

  // Strobe bit masks, ordered as in the strobes vector below
  localparam logic [20:0] S_PCOUT = 21'd1 << 20, S_ZLO  = 21'd1 << 19, S_ZHI  = 21'd1 << 18;
  localparam logic [20:0] S_HIOUT = 21'd1 << 17, S_LOOUT = 21'd1 << 16, S_MDROUT = 21'd1 << 15;
  localparam logic [20:0] S_COUT  = 21'd1 << 14, S_PCIN = 21'd1 << 13, S_MARIN = 21'd1 << 12;
  localparam logic [20:0] S_MDRIN = 21'd1 << 11, S_IRIN = 21'd1 << 10, S_YIN  = 21'd1 << 9;
  localparam logic [20:0] S_ZIN   = 21'd1 << 8,  S_HIIN = 21'd1 << 7,  S_LOIN = 21'd1 << 6;
  localparam logic [20:0] S_READ  = 21'd1 << 5,  S_GRA  = 21'd1 << 4,  S_GRB  = 21'd1 << 3;
  localparam logic [20:0] S_GRC   = 21'd1 << 2,  S_RIN  = 21'd1 << 1,  S_ROUT = 21'd1;

  localparam logic [20:0] X_T0 = S_PCOUT | S_MARIN | S_ZIN;
  localparam logic [20:0] X_T1 = S_ZLO | S_PCIN | S_READ | S_MDRIN;
  localparam logic [20:0] X_T2 = S_MDROUT | S_IRIN;
  localparam logic [20:0] X_R3 = S_GRB | S_ROUT | S_YIN;
  localparam logic [20:0] X_R4 = S_GRC | S_ROUT | S_ZIN;
  localparam logic [20:0] X_R5 = S_ZLO | S_GRA | S_RIN;
  localparam logic [20:0] X_I4 = S_COUT | S_ZIN;
  localparam logic [20:0] X_M3 = S_GRA | S_ROUT | S_YIN;
  localparam logic [20:0] X_M4 = S_GRB | S_ROUT | S_ZIN;
  localparam logic [20:0] X_M5 = S_ZLO | S_LOIN;
  localparam logic [20:0] X_M6 = S_ZHI | S_HIIN;

  localparam logic [31:0] IR_AND  = 32'h28918000;
  localparam logic [31:0] IR_SHRA = 32'h409A8000;
  localparam logic [31:0] IR_MUL  = 32'h78980000;
  localparam logic [31:0] IR_ADDI = 32'h60918000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_SUB  = 32'h20918000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  logic [20:0] strobes;
  assign strobes = {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout, PCin, MARin, MDRin,
                    IRin, Yin, Zin, HIin, LOin, Read, Gra, Grb, Grc, Rin, Rout};

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    logic        stp;
    logic        rst;
    logic [20:0] st;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] ir, logic mr, logic stp, logic rst,
                              logic [20:0] st, logic [4:0] alu, logic run, logic ill);
    vec_t v;
    v.ir = ir; v.mr = mr; v.stp = stp; v.rst = rst;
    v.st = st; v.alu = alu; v.run = run; v.ill = ill;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(string name, logic [20:0] st, logic [4:0] alu, logic run, logic ill);
    total++;
    if (strobes !== st || ALU_Control !== alu || Run !== run || illegal_op !== ill) begin
      bad++;
      $display("FAIL %s: got strobes=%021b alu=%0d run=%b ill=%b, want strobes=%021b alu=%0d run=%b ill=%b",
               name, strobes, ALU_Control, Run, illegal_op, st, alu, run, ill);
    end else begin
      $display("ok   %s: strobes=%021b alu=%0d run=%b ill=%b", name, strobes, ALU_Control, Run, illegal_op);
    end
  endtask

  // From a sampled T0, run one instruction and count cycles until the next T0.
  task automatic measure(string name, logic [31:0] ir, int want);
    int n;
    n = 0;
    IR = ir; mem_ready = 1'b1; stop = 1'b0; clr = 1'b0;
    do begin
      step();
      n++;
    end while (!(PCout && MARin && ALU_Control == 5'd12) && n < 40);
    total++;
    if (n != want) begin
      bad++;
      $display("FAIL %s: cycles got=%0d want=%0d", name, n, want);
    end else begin
      $display("ok   %s: cycles=%0d", name, n);
    end
  endtask

  initial begin
    clr = 1'b1; mem_ready = 1'b1; stop = 1'b0; IR = 32'h0;

    vecs.push_back(mk(32'h0,   1, 0, 1, 21'd0, 5'd0, 1, 0));  // RESET
    vecs.push_back(mk(32'h0,   1, 0, 0, X_T0, 5'd12, 1, 0));
    vecs.push_back(mk(32'h0,   1, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(32'h0,   1, 0, 0, X_T2, 5'd0, 1, 0));
    vecs.push_back(mk(IR_AND,  1, 0, 0, X_R3, 5'd0, 1, 0));
    vecs.push_back(mk(IR_AND,  1, 0, 0, X_R4, 5'd3, 1, 0));
    vecs.push_back(mk(IR_AND,  1, 0, 0, X_R5, 5'd0, 1, 0));
    vecs.push_back(mk(IR_AND,  1, 0, 0, X_T0, 5'd12, 1, 0));
    vecs.push_back(mk(IR_AND,  0, 0, 0, X_T1, 5'd0, 1, 0));   // stall 3 cycles
    vecs.push_back(mk(IR_AND,  0, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_AND,  0, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_AND,  0, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_AND,  1, 0, 0, X_T2, 5'd0, 1, 0));
    vecs.push_back(mk(IR_SHRA, 1, 0, 0, X_R3, 5'd0, 1, 0));
    vecs.push_back(mk(IR_SHRA, 1, 0, 0, X_R4, 5'd9, 1, 0));
    vecs.push_back(mk(IR_SHRA, 1, 0, 0, X_R5, 5'd0, 1, 0));
    vecs.push_back(mk(IR_SHRA, 1, 0, 0, X_T0, 5'd12, 1, 0));
    vecs.push_back(mk(IR_SHRA, 1, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_SHRA, 1, 0, 0, X_T2, 5'd0, 1, 0));
    vecs.push_back(mk(IR_MUL,  1, 0, 0, X_M3, 5'd0, 1, 0));
    vecs.push_back(mk(IR_MUL,  1, 0, 0, X_M4, 5'd5, 1, 0));
    vecs.push_back(mk(IR_MUL,  1, 0, 0, X_M5, 5'd0, 1, 0));
    vecs.push_back(mk(IR_MUL,  1, 0, 0, X_M6, 5'd0, 1, 0));
    vecs.push_back(mk(IR_MUL,  1, 0, 0, X_T0, 5'd12, 1, 0));
    vecs.push_back(mk(IR_MUL,  1, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_MUL,  1, 0, 0, X_T2, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ADDI, 1, 0, 0, X_R3, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ADDI, 1, 0, 0, X_I4, 5'd1, 1, 0));
    vecs.push_back(mk(IR_ADDI, 1, 0, 0, X_R5, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ADDI, 1, 0, 0, X_T0, 5'd12, 1, 0));
    vecs.push_back(mk(IR_ADDI, 1, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ADDI, 1, 0, 0, X_T2, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ILL,  1, 0, 0, 21'd0, 5'd0, 1, 1));  // illegal T3
    vecs.push_back(mk(IR_ILL,  1, 0, 0, X_T0, 5'd12, 1, 0));
    vecs.push_back(mk(IR_ILL,  1, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ILL,  1, 0, 0, X_T2, 5'd0, 1, 0));
    vecs.push_back(mk(IR_NOP,  1, 0, 0, 21'd0, 5'd0, 1, 0));  // NOP T3
    vecs.push_back(mk(IR_NOP,  1, 1, 0, 21'd0, 5'd0, 0, 0));  // stop -> HALT
    vecs.push_back(mk(IR_NOP,  1, 0, 0, 21'd0, 5'd0, 0, 0));
    vecs.push_back(mk(IR_NOP,  1, 0, 1, 21'd0, 5'd0, 1, 0));  // clr -> RESET
    vecs.push_back(mk(IR_NOP,  1, 0, 0, X_T0, 5'd12, 1, 0));
    vecs.push_back(mk(IR_NOP,  1, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_NOP,  1, 0, 0, X_T2, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ADD,  1, 0, 0, X_R3, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ADD,  1, 0, 0, X_R4, 5'd1, 1, 0));
    vecs.push_back(mk(IR_ADD,  1, 0, 1, 21'd0, 5'd0, 1, 0));  // clr in T4 -> RESET, no Rin
    vecs.push_back(mk(IR_ADD,  1, 0, 0, X_T0, 5'd12, 1, 0));
    vecs.push_back(mk(IR_ADD,  1, 0, 0, X_T1, 5'd0, 1, 0));
    vecs.push_back(mk(IR_ADD,  1, 0, 0, X_T2, 5'd0, 1, 0));
    vecs.push_back(mk(IR_SUB,  1, 1, 0, X_R3, 5'd0, 1, 0));   // stop mid-instruction
    vecs.push_back(mk(IR_SUB,  1, 1, 0, X_R4, 5'd2, 1, 0));
    vecs.push_back(mk(IR_SUB,  1, 1, 0, X_R5, 5'd0, 1, 0));
    vecs.push_back(mk(IR_SUB,  1, 1, 0, 21'd0, 5'd0, 0, 0));  // completes, then HALT
    vecs.push_back(mk(IR_SUB,  1, 1, 1, 21'd0, 5'd0, 1, 0));
    vecs.push_back(mk(IR_SUB,  1, 0, 0, X_T0, 5'd12, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      IR = vecs[i].ir; mem_ready = vecs[i].mr; stop = vecs[i].stp; clr = vecs[i].rst;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].alu, vecs[i].run, vecs[i].ill);
    end

    // Now sampled in T0: cycle counts per instruction class.
    measure("cyc_and", IR_AND, 6);
    measure("cyc_mul", IR_MUL, 7);
    measure("cyc_nop", IR_NOP, 4);
    measure("cyc_ill", IR_ILL, 4);

    // HALT opcode: T0 -> T1 -> T2 -> T3 -> HALT, then held for 20 cycles.
    IR = IR_HALT;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 20; i++) begin
      step();
      check_outs($sformatf("halt%0d", i), 21'd0, 5'd0, 1'b0, 1'b0);
    end
    clr = 1'b1;
    step();
    check_outs("halt_clr", 21'd0, 5'd0, 1'b1, 1'b0);
    clr = 1'b0;
    step();
    check_outs("halt_t0", X_T0, 5'd12, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
